// File: rtl/axi_lite_reg_arbiter.sv
// axi_lite_reg_arbiter
// Shares one AXI4-Lite master port between two register requesters.
// Each request is granted round-robin and then runs as a single AXI4-Lite
// write (AW/W/B) or read (AR/R). The owner gets a one-cycle done pulse,
// together with the response and, for reads, the read data.
// Only one transaction is in flight at any time.

module axi_lite_reg_arbiter #(
  parameter int C_ADDR_WIDTH   = 4,
  parameter int C_DATA_WIDTH   = 32,
  parameter int C_ERRCNT_WIDTH = 8
) (
  input  logic                      ACLK,
  input  logic                      ARESET,

  input  logic                      req0_valid,
  input  logic                      req0_we,
  input  logic [C_ADDR_WIDTH-1:0]   req0_addr,
  input  logic [C_DATA_WIDTH-1:0]   req0_wdata,
  input  logic [3:0]                req0_wstrb,
  output logic                      req0_done,
  output logic [C_DATA_WIDTH-1:0]   req0_rdata,
  output logic [1:0]                req0_resp,

  input  logic                      req1_valid,
  input  logic                      req1_we,
  input  logic [C_ADDR_WIDTH-1:0]   req1_addr,
  input  logic [C_DATA_WIDTH-1:0]   req1_wdata,
  input  logic [3:0]                req1_wstrb,
  output logic                      req1_done,
  output logic [C_DATA_WIDTH-1:0]   req1_rdata,
  output logic [1:0]                req1_resp,

  output logic [1:0]                grant,
  output logic [C_ERRCNT_WIDTH-1:0] err_cnt,

  output logic [C_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                M_AXI_AWPROT,
  output logic                      M_AXI_AWVALID,
  input  logic                      M_AXI_AWREADY,
  output logic [C_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [3:0]                M_AXI_WSTRB,
  output logic                      M_AXI_WVALID,
  input  logic                      M_AXI_WREADY,
  input  logic [1:0]                M_AXI_BRESP,
  input  logic                      M_AXI_BVALID,
  output logic                      M_AXI_BREADY,
  output logic [C_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                M_AXI_ARPROT,
  output logic                      M_AXI_ARVALID,
  input  logic                      M_AXI_ARREADY,
  input  logic [C_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                M_AXI_RRESP,
  input  logic                      M_AXI_RVALID,
  output logic                      M_AXI_RREADY
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD      = 3'd3,
    ST_RD_DATA = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  localparam logic [C_ERRCNT_WIDTH-1:0] ERR_ONE = C_ERRCNT_WIDTH'(1);
  localparam logic [C_ERRCNT_WIDTH-1:0] ERR_MAX = {C_ERRCNT_WIDTH{1'b1}};

  state_t                      state_q, state_d;
  logic                        last_grant_q, last_grant_d;  // index of the most recent owner
  logic [1:0]                  grant_q, grant_d;
  logic                        we_q, we_d;
  logic [C_ADDR_WIDTH-1:0]     addr_q, addr_d;              // word aligned at capture
  logic [C_DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [3:0]                  wstrb_q, wstrb_d;
  logic                        awvalid_q, awvalid_d;
  logic                        wvalid_q, wvalid_d;
  logic                        aw_done_q, aw_done_d;
  logic                        w_done_q, w_done_d;
  logic                        bready_q, bready_d;
  logic                        arvalid_q, arvalid_d;
  logic                        rready_q, rready_d;
  logic                        done0_q, done0_d;
  logic                        done1_q, done1_d;
  logic [C_DATA_WIDTH-1:0]     rdata0_q, rdata0_d;
  logic [C_DATA_WIDTH-1:0]     rdata1_q, rdata1_d;
  logic [1:0]                  resp0_q, resp0_d;
  logic [1:0]                  resp1_q, resp1_d;
  logic [C_ERRCNT_WIDTH-1:0]   err_cnt_q, err_cnt_d;

  logic                        sel_s;
  logic                        aw_hs_s;
  logic                        w_hs_s;
  logic                        fin_s;
  logic                        fin_rd_s;
  logic [1:0]                  fin_resp_s;
  logic [C_DATA_WIDTH-1:0]     fin_rdata_s;

  // Byte-offset bits of the request addresses are intentionally dropped.
  logic                        unused_addr_lsb;
  assign unused_addr_lsb = ^{req0_addr[1:0], req1_addr[1:0]};

  // Arbitration, AXI handshake sequencing and completion bookkeeping
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    bready_d     = bready_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    done0_d      = 1'b0;
    done1_d      = 1'b0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    resp0_d      = resp0_q;
    resp1_d      = resp1_q;
    err_cnt_d    = err_cnt_q;
    sel_s        = 1'b0;
    fin_s        = 1'b0;
    fin_rd_s     = 1'b0;
    fin_resp_s   = 2'b00;
    fin_rdata_s  = {C_DATA_WIDTH{1'b0}};
    aw_hs_s      = awvalid_q & M_AXI_AWREADY;
    w_hs_s       = wvalid_q & M_AXI_WREADY;

    case (state_q)
      ST_IDLE: begin
        // On a tie the requester that did not own the bus last time wins.
        if (req0_valid && req1_valid) begin
          sel_s = ~last_grant_q;
        end else if (req1_valid) begin
          sel_s = 1'b1;
        end else begin
          sel_s = 1'b0;
        end

        if (req0_valid || req1_valid) begin
          last_grant_d = sel_s;
          grant_d      = sel_s ? 2'b10 : 2'b01;
          we_d         = sel_s ? req1_we : req0_we;
          addr_d       = {(sel_s ? req1_addr[C_ADDR_WIDTH-1:2] : req0_addr[C_ADDR_WIDTH-1:2]), 2'b00};
          wdata_d      = sel_s ? req1_wdata : req0_wdata;
          wstrb_d      = sel_s ? req1_wstrb : req0_wstrb;
          if (sel_s ? req1_we : req0_we) begin
            state_d   = ST_WR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end else begin
            state_d   = ST_RD;
            arvalid_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_WR: begin
        // AW and W complete independently; leave once both have been accepted.
        if (aw_hs_s) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end else begin
          awvalid_d = awvalid_q;
        end
        if (w_hs_s) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end else begin
          wvalid_d = wvalid_q;
        end
        if ((aw_done_q || aw_hs_s) && (w_done_q || w_hs_s)) begin
          state_d   = ST_WR_RESP;
          bready_d  = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end else begin
          state_d = ST_WR;
        end
      end

      ST_WR_RESP: begin
        if (M_AXI_BVALID) begin
          bready_d   = 1'b0;
          fin_s      = 1'b1;
          fin_resp_s = M_AXI_BRESP;
          state_d    = ST_DONE;
        end else begin
          state_d = ST_WR_RESP;
        end
      end

      ST_RD: begin
        if (arvalid_q && M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RD_DATA;
        end else begin
          state_d = ST_RD;
        end
      end

      ST_RD_DATA: begin
        if (M_AXI_RVALID) begin
          rready_d    = 1'b0;
          fin_s       = 1'b1;
          fin_rd_s    = 1'b1;
          fin_resp_s  = M_AXI_RRESP;
          fin_rdata_s = M_AXI_RDATA;
          state_d     = ST_DONE;
        end else begin
          state_d = ST_RD_DATA;
        end
      end

      ST_DONE: begin
        grant_d = 2'b00;
        state_d = ST_IDLE;
      end

      default: begin
        state_d   = ST_IDLE;
        grant_d   = 2'b00;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        bready_d  = 1'b0;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
      end
    endcase

    // Completion results land in the DONE cycle, routed to the current owner.
    if (fin_s) begin
      if (last_grant_q) begin
        done1_d = 1'b1;
        resp1_d = fin_resp_s;
        if (fin_rd_s) begin
          rdata1_d = fin_rdata_s;
        end else begin
          rdata1_d = rdata1_q;
        end
      end else begin
        done0_d = 1'b1;
        resp0_d = fin_resp_s;
        if (fin_rd_s) begin
          rdata0_d = fin_rdata_s;
        end else begin
          rdata0_d = rdata0_q;
        end
      end
      if ((fin_resp_s != 2'b00) && (err_cnt_q != ERR_MAX)) begin
        err_cnt_d = err_cnt_q + ERR_ONE;
      end else begin
        err_cnt_d = err_cnt_q;
      end
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 2'b00;
      we_q         <= 1'b0;
      addr_q       <= {C_ADDR_WIDTH{1'b0}};
      wdata_q      <= {C_DATA_WIDTH{1'b0}};
      wstrb_q      <= 4'b0000;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      bready_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      rdata0_q     <= {C_DATA_WIDTH{1'b0}};
      rdata1_q     <= {C_DATA_WIDTH{1'b0}};
      resp0_q      <= 2'b00;
      resp1_q      <= 2'b00;
      err_cnt_q    <= {C_ERRCNT_WIDTH{1'b0}};
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      bready_q     <= bready_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      done0_q      <= done0_d;
      done1_q      <= done1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      resp0_q      <= resp0_d;
      resp1_q      <= resp1_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign req0_done     = done0_q;
  assign req0_rdata    = rdata0_q;
  assign req0_resp     = resp0_q;
  assign req1_done     = done1_q;
  assign req1_rdata    = rdata1_q;
  assign req1_resp     = resp1_q;
  assign grant         = grant_q;
  assign err_cnt       = err_cnt_q;

  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axi_lite_reg_arbiter.sv
// Testbench for axi_lite_reg_arbiter.
// Contains:
//   - a reactive AXI4-Lite slave holding a 4-word register bank,
//   - a request-level reference model that feeds per-port scoreboard queues,
//   - a monitor that checks every done pulse against those queues.

module tb_axi_lite_reg_arbiter;

  logic        ACLK;
  logic        ARESET;
  logic        rv    [2];
  logic        rwe   [2];
  logic [3:0]  raddr [2];
  logic [31:0] rwd   [2];
  logic [3:0]  rstb  [2];
  logic        done0, done1;
  logic [31:0] rdata0, rdata1;
  logic [1:0]  resp0, resp1;
  logic [1:0]  grant;
  logic [7:0]  err_cnt;
  logic [3:0]  AWADDR, ARADDR;
  logic [2:0]  AWPROT, ARPROT;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [31:0] WDATA, RDATA;
  logic [3:0]  WSTRB;
  logic [1:0]  BRESP, RRESP;

  axi_lite_reg_arbiter dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .req0_valid(rv[0]), .req0_we(rwe[0]), .req0_addr(raddr[0]), .req0_wdata(rwd[0]),
    .req0_wstrb(rstb[0]), .req0_done(done0), .req0_rdata(rdata0), .req0_resp(resp0),
    .req1_valid(rv[1]), .req1_we(rwe[1]), .req1_addr(raddr[1]), .req1_wdata(rwd[1]),
    .req1_wstrb(rstb[1]), .req1_done(done1), .req1_rdata(rdata1), .req1_resp(resp1),
    .grant(grant), .err_cnt(err_cnt),
    .M_AXI_AWADDR(AWADDR), .M_AXI_AWPROT(AWPROT), .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
    .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB), .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY),
    .M_AXI_BRESP(BRESP), .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY),
    .M_AXI_ARADDR(ARADDR), .M_AXI_ARPROT(ARPROT), .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
    .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP), .M_AXI_RVALID(RVALID), .M_AXI_RREADY(RREADY)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // ---------------- slave configuration and state ----------------
  int          aw_delay  = 0;
  logic [1:0]  bresp_cfg = 2'b00;
  logic [1:0]  rresp_cfg = 2'b00;
  bit          r_block   = 1'b0;
  logic [31:0] sl_mem [4];

  initial begin
    bit          rst_seen, hs_aw, hs_w, hs_b, hs_ar, hs_r;
    bit          got_aw, got_w, got_ar;
    int          awv_cnt;
    logic [3:0]  sl_awaddr, sl_araddr, sl_wstrb;
    logic [31:0] sl_wdata;
    for (int i = 0; i < 4; i++) sl_mem[i] = 32'h0;
    AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00;
    ARREADY = 1'b0; RVALID = 1'b0; RDATA = 32'h0; RRESP = 2'b00;
    got_aw = 1'b0; got_w = 1'b0; got_ar = 1'b0; awv_cnt = 0;
    sl_awaddr = 4'h0; sl_araddr = 4'h0; sl_wstrb = 4'h0; sl_wdata = 32'h0;
    forever begin
      @(negedge ACLK);
      rst_seen = (ARESET === 1'b1);
      hs_aw = (AWVALID === 1'b1) && AWREADY;
      hs_w  = (WVALID === 1'b1) && WREADY;
      hs_b  = BVALID && (BREADY === 1'b1);
      hs_ar = (ARVALID === 1'b1) && ARREADY;
      hs_r  = RVALID && (RREADY === 1'b1);
      if (hs_aw) begin
        sl_awaddr = AWADDR;
        chk("awaddr_aligned", {62'h0, AWADDR[1:0]}, 64'h0);
        chk("awprot", {61'h0, AWPROT}, 64'h0);
        awv_cnt = 0;
      end else if (AWVALID === 1'b1) begin
        awv_cnt++;
      end else begin
        awv_cnt = 0;
      end
      if (hs_w) begin
        sl_wdata = WDATA;
        sl_wstrb = WSTRB;
      end
      if (hs_ar) begin
        sl_araddr = ARADDR;
        chk("araddr_aligned", {62'h0, ARADDR[1:0]}, 64'h0);
        chk("arprot", {61'h0, ARPROT}, 64'h0);
      end
      @(posedge ACLK);
      #1;
      if (rst_seen) begin
        got_aw = 1'b0; got_w = 1'b0; got_ar = 1'b0; awv_cnt = 0;
        BVALID = 1'b0; RVALID = 1'b0;
      end else begin
        if (hs_aw) got_aw = 1'b1;
        if (hs_w)  got_w  = 1'b1;
        if (hs_ar) got_ar = 1'b1;
        if (hs_b)  BVALID = 1'b0;
        if (hs_r)  RVALID = 1'b0;
        if (got_aw && got_w) begin
          sl_mem[sl_awaddr[3:2]] = merge(sl_mem[sl_awaddr[3:2]], sl_wdata, sl_wstrb);
          BVALID = 1'b1; BRESP = bresp_cfg;
          got_aw = 1'b0; got_w = 1'b0;
        end
        if (got_ar && !r_block) begin
          RVALID = 1'b1; RDATA = sl_mem[sl_araddr[3:2]]; RRESP = rresp_cfg;
          got_ar = 1'b0;
        end
      end
      AWREADY = (AWVALID === 1'b1) && (awv_cnt >= aw_delay);
      WREADY  = (WVALID === 1'b1);
      ARREADY = (ARVALID === 1'b1);
    end
  end

  // ---------------- reference model and scoreboard ----------------
  logic [31:0] ref_mem [4];
  logic [31:0] ref_last_rdata [2];
  int          ref_err;
  logic [33:0] exp0_q [$];
  logic [33:0] exp1_q [$];
  int          done_cnt [2];
  int          done_log [$];
  logic [1:0]  grant_log [$];

  task automatic push_exp(input int p, input bit we, input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [33:0] e;
    if (we) begin
      ref_mem[a[3:2]] = merge(ref_mem[a[3:2]], d, s);
      e = {bresp_cfg, ref_last_rdata[p]};
    end else begin
      ref_last_rdata[p] = ref_mem[a[3:2]];
      e = {rresp_cfg, ref_mem[a[3:2]]};
    end
    if (p == 0) exp0_q.push_back(e); else exp1_q.push_back(e);
  endtask

  // Monitor: check each done pulse against the head of that port's queue.
  initial begin
    logic [33:0] e;
    logic [1:0]  prev_grant;
    prev_grant = 2'b00;
    done_cnt[0] = 0; done_cnt[1] = 0;
    forever begin
      @(negedge ACLK);
      if (done0 === 1'b1 && done1 === 1'b1) chk("both_done", 64'h1, 64'h0);
      for (int p = 0; p < 2; p++) begin
        if ((p == 0 ? done0 : done1) === 1'b1) begin
          done_cnt[p]++;
          done_log.push_back(p);
          if ((p == 0 ? exp0_q.size() : exp1_q.size()) == 0) begin
            chk("unexpected_done", 64'(p + 1), 64'h0);
          end else begin
            e = (p == 0) ? exp0_q.pop_front() : exp1_q.pop_front();
            chk(p == 0 ? "req0_resp" : "req1_resp", {62'h0, (p == 0 ? resp0 : resp1)}, {62'h0, e[33:32]});
            chk(p == 0 ? "req0_rdata" : "req1_rdata", {32'h0, (p == 0 ? rdata0 : rdata1)}, {32'h0, e[31:0]});
            if (e[33:32] != 2'b00 && ref_err < 255) ref_err++;
            chk("err_cnt", {56'h0, err_cnt}, 64'(ref_err));
          end
        end
      end
      if (grant !== 2'b00 && prev_grant === 2'b00) grant_log.push_back(grant);
      prev_grant = grant;
    end
  end

  // Channel activity counters for the delayed-AWREADY scenario.
  int awv_hi = 0, wv_hi = 0, aw_chg = 0, bready_early = 0;
  initial begin
    logic       prev_awv;
    logic [3:0] prev_awaddr;
    prev_awv = 1'b0; prev_awaddr = 4'h0;
    forever begin
      @(negedge ACLK);
      if (AWVALID === 1'b1) awv_hi++;
      if (WVALID === 1'b1) wv_hi++;
      if (AWVALID === 1'b1 && prev_awv && AWADDR !== prev_awaddr) aw_chg++;
      if (BREADY === 1'b1 && (AWVALID === 1'b1 || WVALID === 1'b1)) bready_early++;
      prev_awv = (AWVALID === 1'b1);
      prev_awaddr = AWADDR;
    end
  end

  // ---------------- requester side ----------------
  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic drive(input int p, input bit we, input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    rwe[p] = we; raddr[p] = a; rwd[p] = d; rstb[p] = s; rv[p] = 1'b1;
  endtask

  // Issue one request, wait (bounded) for its done pulse, then release.
  task automatic issue(input int p, input bit we, input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    int t;
    push_exp(p, we, a, d, s);
    drive(p, we, a, d, s);
    t = 0;
    do begin
      @(negedge ACLK);
      t++;
    end while ((p == 0 ? done0 : done1) !== 1'b1 && t < 80);
    if ((p == 0 ? done0 : done1) !== 1'b1) chk("done_timeout", 64'h0, 64'h1);
    step();
    rv[p] = 1'b0;
  endtask

  // Zero-wait request with cycle-exact latency checks.
  task automatic directed(input int p, input bit we, input logic [3:0] a, input logic [31:0] d);
    push_exp(p, we, a, d, 4'hF);
    drive(p, we, a, d, 4'hF);
    @(negedge ACLK);
    chk("lat_c0_grant", {62'h0, grant}, 64'h0);
    @(negedge ACLK);
    chk("lat_c1_grant", {62'h0, grant}, (p == 0) ? 64'h1 : 64'h2);
    if (we) begin
      chk("lat_c1_awvalid", {63'h0, AWVALID}, 64'h1);
      chk("lat_c1_wvalid", {63'h0, WVALID}, 64'h1);
      chk("lat_c1_awaddr", {60'h0, AWADDR}, {60'h0, a[3:2], 2'b00});
    end else begin
      chk("lat_c1_arvalid", {63'h0, ARVALID}, 64'h1);
      chk("lat_c1_araddr", {60'h0, ARADDR}, {60'h0, a[3:2], 2'b00});
    end
    @(negedge ACLK);
    chk("lat_c2_ready", {63'h0, (we ? BREADY : RREADY)}, 64'h1);
    @(negedge ACLK);
    chk("lat_c3_done", {63'h0, (p == 0 ? done0 : done1)}, 64'h1);
    step();
    rv[p] = 1'b0;
  endtask

  task automatic do_reset();
    ARESET = 1'b1;
    rv[0] = 1'b0; rv[1] = 1'b0;
    @(posedge ACLK);
    step();
    ARESET = 1'b0;
    ref_last_rdata[0] = 32'h0; ref_last_rdata[1] = 32'h0;
    ref_err = 0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int d0, a0, w0, c0, b0;
    ARESET = 1'b1;
    for (int p = 0; p < 2; p++) begin
      rv[p] = 1'b0; rwe[p] = 1'b0; raddr[p] = 4'h0; rwd[p] = 32'h0; rstb[p] = 4'h0;
    end
    for (int i = 0; i < 4; i++) ref_mem[i] = 32'h0;
    do_reset();

    // Reset state
    @(negedge ACLK);
    chk("rst_grant", {62'h0, grant}, 64'h0);
    chk("rst_err_cnt", {56'h0, err_cnt}, 64'h0);
    chk("rst_done", {62'h0, done1, done0}, 64'h0);
    chk("rst_rdata", {rdata1, rdata0}, 64'h0);
    chk("rst_resp", {60'h0, resp1, resp0}, 64'h0);
    chk("rst_valids", {59'h0, AWVALID, WVALID, ARVALID, BREADY, RREADY}, 64'h0);
    step();

    // 1: single zero-wait write from req0
    directed(0, 1'b1, 4'h4, 32'hA5A5_0001);

    // 2: req1 fills all four registers, then reads them back
    for (int i = 0; i < 4; i++) issue(1, 1'b1, 4'(i * 4), 32'(i + 1), 4'hF);
    for (int i = 0; i < 4; i++) issue(1, 1'b0, 4'(i * 4), 32'h0, 4'h0);

    // 3: both requesters contend for four reads each right after reset
    do_reset();
    grant_log.delete();
    done_log.delete();
    fork
      begin
        for (int i = 0; i < 4; i++) issue(0, 1'b0, 4'($urandom_range(0, 15)), 32'h0, 4'h0);
      end
      begin
        for (int i = 0; i < 4; i++) issue(1, 1'b0, 4'($urandom_range(0, 15)), 32'h0, 4'h0);
      end
    join
    chk("rr_grant_count", 64'(grant_log.size()), 64'd8);
    for (int i = 0; i < 8; i++) begin
      chk("rr_grant_seq", {62'h0, (i < grant_log.size()) ? grant_log[i] : 2'b11}, (i % 2 == 0) ? 64'h1 : 64'h2);
      chk("rr_done_seq", 64'((i < done_log.size()) ? done_log[i] : 9), 64'(i % 2));
    end

    // 4: AWREADY held off for three cycles, WREADY immediate
    aw_delay = 3;
    d0 = done_cnt[0]; a0 = awv_hi; w0 = wv_hi; c0 = aw_chg; b0 = bready_early;
    issue(0, 1'b1, 4'hB, 32'hDEAD_BEEF, 4'hF);
    chk("dly_awvalid_cycles", 64'(awv_hi - a0), 64'd4);
    chk("dly_wvalid_cycles", 64'(wv_hi - w0), 64'd1);
    chk("dly_awaddr_stable", 64'(aw_chg - c0), 64'd0);
    chk("dly_bready_early", 64'(bready_early - b0), 64'd0);
    chk("dly_done_count", 64'(done_cnt[0] - d0), 64'd1);
    aw_delay = 0;

    // 5: 256 writes answered with SLVERR; the error counter must saturate
    bresp_cfg = 2'b10;
    for (int i = 0; i < 256; i++)
      issue(int'($urandom_range(0, 1)), 1'b1, 4'($urandom_range(0, 15)), $urandom, 4'hF);
    bresp_cfg = 2'b00;
    chk("err_cnt_saturated", {56'h0, err_cnt}, 64'hFF);
    issue(0, 1'b1, 4'h0, 32'h1234_5678, 4'hF);
    bresp_cfg = 2'b10;
    issue(1, 1'b1, 4'h0, 32'h8765_4321, 4'hF);
    bresp_cfg = 2'b00;
    chk("err_cnt_stays_ff", {56'h0, err_cnt}, 64'hFF);

    // 6: reset while waiting for RVALID
    begin
      int t;
      r_block = 1'b1;
      d0 = done_cnt[0];
      drive(0, 1'b0, 4'h8, 32'h0, 4'h0);
      t = 0;
      do begin
        @(negedge ACLK);
        t++;
      end while (RREADY !== 1'b1 && t < 20);
      chk("abort_reached_rd_data", {63'h0, RREADY}, 64'h1);
      step();
      ARESET = 1'b1;
      rv[0] = 1'b0;
      step();
      ARESET = 1'b0;
      @(negedge ACLK);
      chk("abort_rready", {63'h0, RREADY}, 64'h0);
      chk("abort_grant", {62'h0, grant}, 64'h0);
      chk("abort_err_cnt", {56'h0, err_cnt}, 64'h0);
      chk("abort_no_done", 64'(done_cnt[0] - d0), 64'd0);
      ref_last_rdata[0] = 32'h0; ref_last_rdata[1] = 32'h0;
      ref_err = 0;
      r_block = 1'b0;
      step();
      directed(0, 1'b0, 4'h9, 32'h0);
    end

    // Random mix of reads/writes, strobes, responses and AW back-pressure
    for (int i = 0; i < 60; i++) begin
      aw_delay  = int'($urandom_range(0, 2));
      bresp_cfg = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00;
      rresp_cfg = ($urandom_range(0, 5) == 0) ? 2'b10 : 2'b00;
      issue(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            $urandom, 4'($urandom_range(0, 15)));
    end
    aw_delay = 0; bresp_cfg = 2'b00; rresp_cfg = 2'b00;

    repeat (3) @(negedge ACLK);
    chk("sb_empty_req0", 64'(exp0_q.size()), 64'd0);
    chk("sb_empty_req1", 64'(exp1_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
